// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game sequencer: serve/play/score/game-over FSM and score keeping
//
// Ports:
//   clock         in   system/pixel clock
//   rst_n         in   asynchronous active-low reset (release synchronised internally)
//   ivsync        in   vsync, active high; rising edge is the frame tick
//   istart        in   debounced start request; rising edge starts a serve
//   iballx/ibally in   ball column/row in tiles
//   ip1y/ip2y     in   left/right paddle top row in tiles
//   ogame_active  out  high only while RUNNING
//   op1points     out  player-1 score
//   op2points     out  player-2 score
//   owinner       out  00 none, 01 player 1, 10 player 2
//   ostate        out  current state code
module pong_game_ctrl #(
  parameter int GAME_WIDTH    = 40,
  parameter int PADDLE_HEIGHT = 6,
  parameter int SCORE_LIMIT   = 3,
  parameter int SERVE_FRAMES  = 60
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       ivsync,
  input  logic       istart,
  input  logic [5:0] iballx,
  input  logic [5:0] ibally,
  input  logic [5:0] ip1y,
  input  logic [5:0] ip2y,
  output logic       ogame_active,
  output logic [3:0] op1points,
  output logic [3:0] op2points,
  output logic [1:0] owinner,
  output logic [2:0] ostate
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SERVE    = 3'd1,
    S_RUNNING  = 3'd2,
    S_P1SCORE  = 3'd3,
    S_P2SCORE  = 3'd4,
    S_GAMEOVER = 3'd5
  } state_t;

  localparam logic [5:0] LP_RIGHT_COL = 6'(GAME_WIDTH - 1);
  localparam logic [6:0] LP_PAD_SPAN  = 7'(PADDLE_HEIGHT - 1);
  localparam logic [3:0] LP_LIMIT     = 4'(SCORE_LIMIT);
  localparam logic [8:0] LP_SERVE     = 9'(SERVE_FRAMES);

  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  logic       r_vsync_d;
  logic       r_start_d;
  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_frame_cnt;
  logic [7:0] w_frame_cnt_next;
  logic [3:0] r_p1points;
  logic [3:0] r_p2points;
  logic [3:0] w_p1_next;
  logic [3:0] w_p2_next;
  logic [1:0] r_winner;
  logic [1:0] w_winner_next;
  logic       r_game_active;
  logic       w_tick;
  logic       w_start_rise;
  logic [6:0] w_p1_bottom;
  logic [6:0] w_p2_bottom;
  logic       w_left_miss;
  logic       w_right_miss;

  // Assert immediately, release two clocks after rst_n rises.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Edge history runs on the raw reset so it already holds the live input
  // level when the FSM leaves reset: a start held through reset is not an edge.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d <= 1'b0;
      r_start_d <= 1'b0;
    end else begin
      r_vsync_d <= ivsync;
      r_start_d <= istart;
    end
  end

  assign w_tick       = ivsync & ~r_vsync_d;
  assign w_start_rise = istart & ~r_start_d;

  // 7-bit sums so a paddle near row 63 does not wrap into low rows.
  assign w_p1_bottom  = {1'b0, ip1y} + LP_PAD_SPAN;
  assign w_p2_bottom  = {1'b0, ip2y} + LP_PAD_SPAN;
  assign w_left_miss  = (iballx == 6'd0) &&
                        ((ibally < ip1y) || ({1'b0, ibally} > w_p1_bottom));
  assign w_right_miss = (iballx == LP_RIGHT_COL) &&
                        ((ibally < ip2y) || ({1'b0, ibally} > w_p2_bottom));

  always_comb begin
    w_state_next     = r_state;
    w_frame_cnt_next = r_frame_cnt;
    w_p1_next        = r_p1points;
    w_p2_next        = r_p2points;
    w_winner_next    = r_winner;
    case (r_state)
      S_IDLE: begin
        if (w_start_rise) begin
          w_state_next     = S_SERVE;
          w_frame_cnt_next = 8'd0;
        end
      end
      S_SERVE: begin
        if (w_tick) begin
          if (({1'b0, r_frame_cnt} + 9'd1) == LP_SERVE) w_state_next = S_RUNNING;
          else w_frame_cnt_next = r_frame_cnt + 8'd1;
        end
      end
      S_RUNNING: begin
        if (w_left_miss)       w_state_next = S_P2SCORE;
        else if (w_right_miss) w_state_next = S_P1SCORE;
      end
      S_P1SCORE: begin
        w_p1_next = r_p1points + 4'd1;
        if ((r_p1points + 4'd1) == LP_LIMIT) begin
          w_winner_next = 2'b01;
          w_state_next  = S_GAMEOVER;
        end else begin
          w_state_next  = S_IDLE;
        end
      end
      S_P2SCORE: begin
        w_p2_next = r_p2points + 4'd1;
        if ((r_p2points + 4'd1) == LP_LIMIT) begin
          w_winner_next = 2'b10;
          w_state_next  = S_GAMEOVER;
        end else begin
          w_state_next  = S_IDLE;
        end
      end
      S_GAMEOVER: begin
        if (w_start_rise) begin
          w_p1_next        = 4'd0;
          w_p2_next        = 4'd0;
          w_winner_next    = 2'b00;
          w_frame_cnt_next = 8'd0;
          w_state_next     = S_SERVE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= S_IDLE;
      r_frame_cnt   <= 8'd0;
      r_p1points    <= 4'd0;
      r_p2points    <= 4'd0;
      r_winner      <= 2'b00;
      r_game_active <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_frame_cnt   <= w_frame_cnt_next;
      r_p1points    <= w_p1_next;
      r_p2points    <= w_p2_next;
      r_winner      <= w_winner_next;
      r_game_active <= (w_state_next == S_RUNNING);
    end
  end

  assign ogame_active = r_game_active;
  assign op1points    = r_p1points;
  assign op2points    = r_p2points;
  assign owinner      = r_winner;
  assign ostate       = r_state;

endmodule
